kgp_multicycle_sequencer: RTL and testbench

//  Moore FSM that sequences the KGP-RISC multi-cycle datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/kgp_pkg.sv | 68 ++++++
 rtl/kgp_instr_decode.sv | 78 +++++++
 rtl/kgp_multicycle_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_kgp_multicycle_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// ============================================================================
//  Module      : kgp_pkg
//  Description : Shared types and encodings for the KGP-RISC multi-cycle
//                sequencer: FSM states, instruction classes, opcode/funct
//                values, ALU function codes and branch condition codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kgp_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Instruction classes seen by the sequencer
    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LD     = 3'd2,
        CLS_ST     = 3'd3,
        CLS_BRANCH = 3'd4
    } iclass_t;

    // Opcodes (irout[31:26])
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_I_LAST  = 6'b011010;
    localparam logic [5:0] OP_MOVE    = 6'b011010;
    localparam logic [5:0] OP_LD      = 6'b100001;
    localparam logic [5:0] OP_ST      = 6'b100010;
    localparam logic [5:0] OP_BR      = 6'b110000;
    localparam logic [5:0] OP_BMI     = 6'b110001;
    localparam logic [5:0] OP_BPL     = 6'b110010;
    localparam logic [5:0] OP_BZ      = 6'b110011;

    // R-type funct range (irout[5:0])
    localparam logic [5:0] FUNCT_FIRST = 6'd1;
    localparam logic [5:0] FUNCT_LAST  = 6'd10;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SLA = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;
    localparam logic [3:0] ALU_BRT = 4'b1010;

    // Branch condition codes
    localparam logic [1:0] OPC_BPL  = 2'b00;
    localparam logic [1:0] OPC_BMI  = 2'b01;
    localparam logic [1:0] OPC_BZ   = 2'b10;
    localparam logic [1:0] OPC_NONE = 2'b11;

endpackage : kgp_pkg

`default_nettype wire

// File: rtl/kgp_instr_decode.sv
// ============================================================================
//  Module      : kgp_instr_decode
//  Description : Combinational instruction classifier. Maps the IR contents
//                to instruction class, ALU function, branch condition and an
//                illegal-instruction flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kgp_instr_decode
    import kgp_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output logic [3:0]  alufunc,
    output logic [1:0]  opcond,
    output logic        is_br,
    output logic        illegal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [5:0] w_funct_m1;

    assign w_op       = instr[31:26];
    assign w_funct    = instr[5:0];
    assign w_funct_m1 = w_funct - 6'd1;

    // Classify on the two top opcode bits, then validate the exact opcode
    always_comb begin
        iclass  = CLS_R;
        alufunc = ALU_ADD;
        opcond  = OPC_NONE;
        is_br   = 1'b0;
        illegal = 1'b1;
        case (w_op[5:4])
            2'b00: begin
                if ((w_op == OP_RTYPE) && (w_funct >= FUNCT_FIRST) && (w_funct <= FUNCT_LAST)) begin
                    iclass  = CLS_R;
                    alufunc = w_funct_m1[3:0];
                    illegal = 1'b0;
                end
            end
            2'b01: begin
                if (w_op <= OP_I_LAST) begin
                    iclass  = CLS_I;
                    // MOVE is an add of the immediate to the source
                    alufunc = (w_op == OP_MOVE) ? ALU_ADD : w_op[3:0];
                    illegal = 1'b0;
                end
            end
            2'b10: begin
                if (w_op == OP_LD) begin
                    iclass  = CLS_LD;
                    illegal = 1'b0;
                end else if (w_op == OP_ST) begin
                    iclass  = CLS_ST;
                    illegal = 1'b0;
                end
            end
            default: begin
                iclass  = CLS_BRANCH;
                alufunc = ALU_BRT;
                illegal = 1'b0;
                case (w_op)
                    OP_BR:   is_br  = 1'b1;
                    OP_BMI:  opcond = OPC_BMI;
                    OP_BPL:  opcond = OPC_BPL;
                    OP_BZ:   opcond = OPC_BZ;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule : kgp_instr_decode

`default_nettype wire

// File: rtl/kgp_multicycle_sequencer.sv
// ============================================================================
//  Module      : kgp_multicycle_sequencer
//  Description : Moore FSM sequencing the KGP-RISC multi-cycle datapath
//                through FETCH/DECODE/EXEC/MEM/WB with imem/dmem ready
//                handshakes, a wait timeout and a sticky error state.
//                Optional performance counters when KGP_SEQ_PERF_EN is
//                defined (cycle_cnt, instret_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kgp_multicycle_sequencer
    import kgp_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] irout,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        readim,
    output logic        ldir,
    output logic        ldnpc,
    output logic        ldA,
    output logic        ldB,
    output logic        ldimm,
    output logic [1:0]  opcond,
    output logic        alusel1,
    output logic        alusel2,
    output logic        aluen,
    output logic        ldaluout,
    output logic [3:0]  alufunc,
    output logic        regwrite,
    output logic        writedmem,
    output logic        readdmem,
    output logic        ldlmd,
    output logic        selwb,
    output logic        branch,
    output logic        ldpc,
    output logic        halted,
    output logic        error
`ifdef KGP_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    localparam int               c_to_w    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(MEM_TIMEOUT - 1);
    localparam logic             c_to_en   = (MEM_TIMEOUT != 0);

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_retire_state;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_enter_wait;

    iclass_t             w_iclass;
    logic [3:0]          w_alufunc;
    logic [1:0]          w_opcond;
    logic                w_is_br;
    logic                w_illegal;

    kgp_instr_decode u_decode (
        .instr   (irout),
        .iclass  (w_iclass),
        .alufunc (w_alufunc),
        .opcond  (w_opcond),
        .is_br   (w_is_br),
        .illegal (w_illegal)
    );

    // A retiring instruction goes back to FETCH, or parks in IDLE once run drops
    assign w_retire_state = run ? ST_FETCH : ST_IDLE;

    assign w_waiting    = ((r_state == ST_FETCH) && !imem_ready) ||
                          ((r_state == ST_MEM)   && !dmem_ready);
    assign w_timeout    = c_to_en && w_waiting && (r_to_cnt == c_to_last);
    assign w_enter_wait = (w_next_state != r_state) &&
                          ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait-cycle counter: restarts on each FETCH/MEM entry, counts unready cycles
    always_ff @(posedge clk) begin
        if (reset || w_enter_wait) begin
            r_to_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready)     w_next_state = ST_DECODE;
                else if (w_timeout) w_next_state = ST_ERROR;
            end
            ST_DECODE: begin
                w_next_state = w_illegal ? ST_ERROR : ST_EXEC;
            end
            ST_EXEC: begin
                case (w_iclass)
                    CLS_BRANCH:    w_next_state = w_retire_state;
                    CLS_LD, CLS_ST: w_next_state = ST_MEM;
                    default:       w_next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready)     w_next_state = (w_iclass == CLS_LD) ? ST_WB : w_retire_state;
                else if (w_timeout) w_next_state = ST_ERROR;
            end
            ST_WB: begin
                w_next_state = w_retire_state;
            end
            default: begin
                w_next_state = ST_ERROR;
            end
        endcase
    end

    // Output decode from state and IR; everything quiet while reset is asserted
    always_comb begin
        readim    = 1'b0;
        ldir      = 1'b0;
        ldnpc     = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldimm     = 1'b0;
        opcond    = OPC_NONE;
        alusel1   = 1'b0;
        alusel2   = 1'b0;
        aluen     = 1'b0;
        ldaluout  = 1'b0;
        alufunc   = ALU_ADD;
        regwrite  = 1'b0;
        writedmem = 1'b0;
        readdmem  = 1'b0;
        ldlmd     = 1'b0;
        selwb     = 1'b0;
        branch    = 1'b0;
        ldpc      = 1'b0;
        halted    = 1'b1;
        error     = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    halted = 1'b1;
                end
                ST_FETCH: begin
                    halted = 1'b0;
                    readim = 1'b1;
                    ldir   = imem_ready;
                    ldnpc  = imem_ready;
                end
                ST_DECODE: begin
                    halted = 1'b0;
                    ldA    = 1'b1;
                    ldB    = 1'b1;
                    ldimm  = 1'b1;
                end
                ST_EXEC: begin
                    halted   = 1'b0;
                    aluen    = 1'b1;
                    ldaluout = 1'b1;
                    alufunc  = w_alufunc;
                    case (w_iclass)
                        CLS_R: begin
                            alusel1 = 1'b1;
                            alusel2 = 1'b0;
                        end
                        CLS_BRANCH: begin
                            alusel1 = 1'b0;
                            alusel2 = 1'b1;
                            opcond  = w_opcond;
                            branch  = w_is_br;
                            ldpc    = 1'b1;
                        end
                        default: begin
                            alusel1 = 1'b1;
                            alusel2 = 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    halted = 1'b0;
                    if (w_iclass == CLS_LD) begin
                        readdmem = 1'b1;
                        ldlmd    = dmem_ready;
                    end else begin
                        writedmem = 1'b1;
                        ldpc      = dmem_ready;
                    end
                end
                ST_WB: begin
                    halted   = 1'b0;
                    regwrite = 1'b1;
                    ldpc     = 1'b1;
                    selwb    = (w_iclass == CLS_LD);
                end
                default: begin
                    halted = 1'b1;
                    error  = 1'b1;
                end
            endcase
        end
    end

`ifdef KGP_SEQ_PERF_EN
    // Active-cycle counter: every cycle spent outside IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (r_state != ST_IDLE) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    // Retired-instruction counter: one per ldpc pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_cnt <= '0;
        end else if (ldpc) begin
            instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule : kgp_multicycle_sequencer

`default_nettype wire

// File: tb/tb_kgp_multicycle_sequencer.sv
// ============================================================================
//  Module      : tb_kgp_multicycle_sequencer
//  Description : Self-checking bench for kgp_multicycle_sequencer. A phase
//                model built from the instruction-set rules predicts the
//                full strobe vector every cycle for directed and random
//                instruction streams with random memory wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kgp_multicycle_sequencer;

    localparam int TO = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_MEM   = 4;
    localparam int P_WB    = 5;
    localparam int P_ERR   = 6;

    typedef struct packed {
        logic       readim, ldir, ldnpc, ldA, ldB, ldimm;
        logic [1:0] opcond;
        logic       alusel1, alusel2, aluen, ldaluout;
        logic [3:0] alufunc;
        logic       regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted, error;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] irout = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0]  opcond;
    logic        alusel1, alusel2, aluen, ldaluout;
    logic [3:0]  alufunc;
    logic        regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted, error;
`ifdef KGP_SEQ_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int failures = 0;

    outs_t obs;
    assign obs = {readim, ldir, ldnpc, ldA, ldB, ldimm, opcond, alusel1, alusel2, aluen, ldaluout,
                  alufunc, regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc, halted, error};

    always #5 clk = ~clk;

    kgp_multicycle_sequencer #(.MEM_TIMEOUT(TO), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .irout(irout),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldA(ldA), .ldB(ldB), .ldimm(ldimm),
        .opcond(opcond), .alusel1(alusel1), .alusel2(alusel2), .aluen(aluen),
        .ldaluout(ldaluout), .alufunc(alufunc), .regwrite(regwrite), .writedmem(writedmem),
        .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb), .branch(branch), .ldpc(ldpc),
        .halted(halted), .error(error)
`ifdef KGP_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // Expected strobe vector for one cycle of a given phase, from the ISA rules
    function automatic outs_t expect_outs(input int ph, input logic [31:0] ins, input logic rdy);
        outs_t e;
        int op;
        int funct;
        e = '0;
        e.opcond = 2'b11;
        op = int'(ins[31:26]);
        funct = int'(ins[5:0]);
        case (ph)
            P_IDLE: e.halted = 1'b1;
            P_ERR: begin
                e.halted = 1'b1;
                e.error = 1'b1;
            end
            P_FETCH: begin
                e.readim = 1'b1;
                e.ldir = rdy;
                e.ldnpc = rdy;
            end
            P_DEC: begin
                e.ldA = 1'b1;
                e.ldB = 1'b1;
                e.ldimm = 1'b1;
            end
            P_EXEC: begin
                e.aluen = 1'b1;
                e.ldaluout = 1'b1;
                if (op == 0) begin
                    e.alusel1 = 1'b1;
                    e.alufunc = 4'(funct - 1);
                end else if (op >= 16 && op <= 26) begin
                    e.alusel1 = 1'b1;
                    e.alusel2 = 1'b1;
                    e.alufunc = (op == 26) ? 4'd0 : 4'(op - 16);
                end else if (op == 33 || op == 34) begin
                    e.alusel1 = 1'b1;
                    e.alusel2 = 1'b1;
                end else begin
                    e.alusel2 = 1'b1;
                    e.alufunc = 4'd10;
                    e.ldpc = 1'b1;
                    case (op)
                        48: e.branch = 1'b1;
                        49: e.opcond = 2'b01;
                        50: e.opcond = 2'b00;
                        default: e.opcond = 2'b10;
                    endcase
                end
            end
            P_MEM: begin
                if (op == 33) begin
                    e.readdmem = 1'b1;
                    e.ldlmd = rdy;
                end else begin
                    e.writedmem = 1'b1;
                    e.ldpc = rdy;
                end
            end
            default: begin
                e.regwrite = 1'b1;
                e.ldpc = 1'b1;
                e.selwb = (op == 33);
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 4);
        case (k)
            0: begin
                ins[31:26] = 6'd0;
                ins[5:0] = 6'($urandom_range(1, 10));
            end
            1: ins[31:26] = 6'($urandom_range(16, 26));
            2: ins[31:26] = 6'd33;
            3: ins[31:26] = 6'd34;
            default: ins[31:26] = 6'($urandom_range(48, 51));
        endcase
        return ins;
    endfunction

    task automatic chk(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; sample mid-cycle, then advance past the next edge
    task automatic cyc(input string tag, input outs_t exp);
        @(negedge clk);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        cyc("reset_cycle", expect_outs(P_IDLE, 32'd0, 1'b0));
        reset = 1'b0;
    endtask

    // One IDLE cycle with run high, leaving the FSM in FETCH
    task automatic start_run();
        run = 1'b1;
        cyc("idle_start", expect_outs(P_IDLE, 32'd0, 1'b0));
    endtask

    // One full instruction starting in FETCH with wi/wd memory wait cycles
    task automatic run_instr(input logic [31:0] ins, input int wi, input int wd, input logic run_v);
        int op;
        op = int'(ins[31:26]);
        run = run_v;
        for (int k = 0; k <= wi; k++) begin
            irout = $urandom;
            imem_ready = (k == wi);
            dmem_ready = 1'($urandom_range(0, 1));
            cyc("fetch", expect_outs(P_FETCH, ins, imem_ready));
        end
        irout = ins;
        imem_ready = 1'($urandom_range(0, 1));
        cyc("decode", expect_outs(P_DEC, ins, 1'b0));
        cyc("exec", expect_outs(P_EXEC, ins, 1'b0));
        if (op == 33 || op == 34) begin
            for (int k = 0; k <= wd; k++) begin
                dmem_ready = (k == wd);
                cyc("mem", expect_outs(P_MEM, ins, dmem_ready));
            end
        end
        if (op < 48 && op != 34) begin
            cyc("wb", expect_outs(P_WB, ins, 1'b0));
        end
    endtask

    task automatic run_illegal(input logic [31:0] ins);
        do_reset();
        start_run();
        irout = ins;
        imem_ready = 1'b1;
        cyc("ill_fetch", expect_outs(P_FETCH, ins, 1'b1));
        cyc("ill_decode", expect_outs(P_DEC, ins, 1'b0));
        dmem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("ill_error", expect_outs(P_ERR, ins, 1'b0));
        end
    endtask

    logic [31:0] illegal_tab [4];

    initial begin
        illegal_tab[0] = {6'b101111, 26'h0};
        illegal_tab[1] = {6'b000000, 20'h0, 6'd0};
        illegal_tab[2] = {6'b000000, 20'h0, 6'd11};
        illegal_tab[3] = {6'b011011, 26'h155};

        @(posedge clk);
        #1;
        do_reset();
        cyc("idle_after_reset", expect_outs(P_IDLE, 32'd0, 1'b0));

        // ADD with zero-wait memory, run dropped so the FSM parks in IDLE
        start_run();
        run_instr({6'd0, 20'h0, 6'd1}, 0, 0, 1'b0);
        cyc("idle_after_add", expect_outs(P_IDLE, 32'd0, 1'b0));

        // Directed: LD with three dmem wait cycles, BZ, BR, ST, MOVE
        start_run();
        run_instr({6'b100001, 26'h12345}, 0, 3, 1'b1);
        run_instr({6'b110011, 26'h00abc}, 0, 0, 1'b1);
        run_instr({6'b110000, 26'h3ffff}, 1, 0, 1'b1);
        run_instr({6'b100010, 26'h00042}, 0, 2, 1'b1);
        run_instr({6'b011010, 26'h0000f}, 0, 0, 1'b0);
        cyc("idle_after_directed", expect_outs(P_IDLE, 32'd0, 1'b0));

        // Random instruction stream with random wait states
        start_run();
        for (int n = 0; n < 40; n++) begin
            run_instr(rand_instr(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), n != 39);
        end
        cyc("idle_after_random", expect_outs(P_IDLE, 32'd0, 1'b0));

        // Illegal instructions trap in ERROR until reset
        for (int i = 0; i < 4; i++) run_illegal(illegal_tab[i]);

        // Instruction memory never ready
        do_reset();
        start_run();
        for (int k = 0; k < TO; k++) begin
            imem_ready = 1'b0;
            cyc("imem_wait", expect_outs(P_FETCH, 32'd0, 1'b0));
        end
        imem_ready = 1'b1;
        cyc("imem_timeout", expect_outs(P_ERR, 32'd0, 1'b0));
        cyc("imem_timeout_hold", expect_outs(P_ERR, 32'd0, 1'b0));

        // Data memory never ready on a load
        do_reset();
        start_run();
        irout = {6'b100001, 26'h0};
        imem_ready = 1'b1;
        cyc("dto_fetch", expect_outs(P_FETCH, irout, 1'b1));
        cyc("dto_decode", expect_outs(P_DEC, irout, 1'b0));
        cyc("dto_exec", expect_outs(P_EXEC, irout, 1'b0));
        for (int k = 0; k < TO; k++) begin
            dmem_ready = 1'b0;
            cyc("dmem_wait", expect_outs(P_MEM, irout, 1'b0));
        end
        cyc("dmem_timeout", expect_outs(P_ERR, irout, 1'b0));

        // Reset in the middle of a memory wait
        do_reset();
        start_run();
        irout = {6'b100001, 26'h0};
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        cyc("rst_fetch", expect_outs(P_FETCH, irout, 1'b1));
        cyc("rst_decode", expect_outs(P_DEC, irout, 1'b0));
        cyc("rst_exec", expect_outs(P_EXEC, irout, 1'b0));
        cyc("rst_mem", expect_outs(P_MEM, irout, 1'b0));
        reset = 1'b1;
        cyc("rst_in_mem", expect_outs(P_IDLE, irout, 1'b0));
        reset = 1'b0;
        run = 1'b0;
        cyc("rst_idle_next", expect_outs(P_IDLE, irout, 1'b0));

`ifdef KGP_SEQ_PERF_EN
        // Three ADDs and one LD at zero wait: 4 retired, 3*4+5 active cycles
        do_reset();
        start_run();
        for (int n = 0; n < 3; n++) run_instr({6'd0, 20'h0, 6'd1}, 0, 0, 1'b1);
        run_instr({6'b100001, 26'h0}, 0, 0, 1'b0);
        cyc("perf_idle", expect_outs(P_IDLE, 32'd0, 1'b0));
        checks++;
        assert (instret_cnt === 32'd4) else begin
            failures++;
            $error("FAIL instret_cnt observed=%0d expected=4", instret_cnt);
        end
        checks++;
        assert (cycle_cnt === 32'd17) else begin
            failures++;
            $error("FAIL cycle_cnt observed=%0d expected=17", cycle_cnt);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_kgp_multicycle_sequencer

`default_nettype wire
